mem_stage: RTL
==============

# mem_stage

Memory-access stage of the 16-bit CPU datapath, directly downstream of the ALU. Consumes the ALU result as data-memory address (LWD/SWD) or as pass-through writeback data (ALU_OP/ADI/ORI/LHI). Runs a handshake with a variable-latency data memory, stalls upstream while an access is outstanding, and produces one writeback pulse per completed instruction. Optionally arbitrates the data bus with the DMA controller.

## Interface

Parameters:
- WORD_SIZE, 16, datapath width (matches the `WORD_SIZE` define)

Ports:
- clk  input  1  rising-edge clock
- Reset_N  input  1  asynchronous active-low reset
- in_valid  input  1  upstream instruction present
- Opcode  input  4  instruction opcode (opcodes.v encodings)
- ALUresult  input  WORD_SIZE  ALU output: address or writeback data
- store_data  input  WORD_SIZE  SWD write data
- in_wen  input  1  instruction writes a register
- in_dest  input  2  destination register index
- stall  output  1  upstream must hold its inputs
- d_readM  output  1  memory read request
- d_writeM  output  1  memory write request
- d_address  output  WORD_SIZE  memory address
- d_wdata  output  WORD_SIZE  memory write data
- d_rdata  input  WORD_SIZE  memory read data, valid with d_ack
- d_ack  input  1  memory completes current request
- wb_valid  output  1  one-cycle writeback pulse
- wb_dest  output  2  writeback register index
- wb_data  output  WORD_SIZE  writeback value
- BR  input  1  DMA bus request (DMA_ARB_EN only)
- BG  output  1  bus grant to DMA (DMA_ARB_EN only)

## Operation

- States: IDLE, READ_WAIT, WRITE_WAIT, GRANT (GRANT only with DMA_ARB_EN).
- Instruction accepted at a rising edge when in_valid=1 and stall=0.
- IDLE, accept LWD: latch address=ALUresult, in_dest; -> READ_WAIT.
- IDLE, accept SWD: latch address=ALUresult, d_wdata=store_data; -> WRITE_WAIT.
- IDLE, accept other opcode with in_wen=1: next cycle wb_valid=1, wb_data=ALUresult, wb_dest=in_dest; stay IDLE. in_wen=0 or branch opcodes: accepted, no writeback.
- READ_WAIT: d_readM=1, d_address held. Edge with d_ack=1: latch d_rdata into wb_data, wb_valid=1 next cycle, -> IDLE.
- WRITE_WAIT: d_writeM=1, d_address/d_wdata held. Edge with d_ack=1: -> IDLE, no writeback.
- stall = (state != IDLE); combinational from state.
- d_ack while IDLE (or GRANT) ignored.
- d_readM/d_writeM never both high; d_address=0, d_wdata=0 whenever no request active.
- Inputs other than d_rdata/d_ack/BR ignored while stall=1.

## Timing

- Reset (async assert, any state, including mid-access): state IDLE; stall, d_readM, d_writeM, wb_valid, BG = 0; d_address, d_wdata, wb_data = 0; wb_dest = 0. Outstanding access dropped, no writeback.
- Non-memory writeback latency: 1 cycle after accept.
- LWD: request visible cycle after accept; if d_ack high in the first request cycle, wb_valid the following cycle (minimum 2 cycles accept->wb_valid). Each extra cycle of d_ack low adds one.
- SWD: minimum 1 request cycle; stall drops the cycle after the d_ack edge.
- Back-to-back: new instruction acceptable in the cycle stall drops; wb_valid of previous LWD and writeback of next non-memory op never coincide (minimum one cycle apart by construction).
- wb_valid high exactly one cycle per writing instruction.

## Configuration

- DMA_ARB_EN defined: BR/BG ports and GRANT state present. In IDLE, BR=1 forces stall=1 combinationally (BR beats a pending in_valid); next edge -> GRANT, BG=1. GRANT: stall=1, no memory requests. Edge with BR=0 in GRANT: -> IDLE, BG=0 next cycle. BR rising during READ_WAIT/WRITE_WAIT honoured only after access completes and state returns to IDLE.
- DMA_ARB_EN undefined: no BR/BG ports, no GRANT state; stall depends on state only.

## Test plan

- Reset mid-READ_WAIT with d_ack low -> all outputs 0 immediately, no wb_valid after release.
- ADI, ALUresult=16'h0042, in_wen=1, in_dest=2 -> wb_valid 1 cycle later, wb_data=16'h0042, wb_dest=2, stall never high.
- LWD, ALUresult=16'h0010, d_ack delayed 3 cycles, d_rdata=16'hBEEF -> d_readM=1, d_address=16'h0010 for 3 cycles, stall high 3 cycles, wb_data=16'hBEEF pulse.
- SWD addr 16'h0020 data 16'h1234, d_ack same first cycle -> d_writeM one cycle, no wb_valid, stall 1 cycle.
- LWD followed immediately by ORI held under stall -> ORI accepted the cycle stall drops, two distinct wb_valid pulses in order.
- DMA_ARB_EN: BR=1 while SWD pending in WRITE_WAIT -> BG stays 0 until d_ack, GRANT entered next IDLE edge, BG=1 until one cycle after BR=0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: turns ALU results into data-memory requests or direct writebacks.
// Optional DMA bus arbitration (BR/BG ports, GRANT state) is enabled by defining DMA_ARB_EN.
module mem_stage #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 Reset_N,
    input  logic                 in_valid,
    input  logic [3:0]           Opcode,
    input  logic [WORD_SIZE-1:0] ALUresult,
    input  logic [WORD_SIZE-1:0] store_data,
    input  logic                 in_wen,
    input  logic [1:0]           in_dest,
    output logic                 stall,
    output logic                 d_readM,
    output logic                 d_writeM,
    output logic [WORD_SIZE-1:0] d_address,
    output logic [WORD_SIZE-1:0] d_wdata,
    input  logic [WORD_SIZE-1:0] d_rdata,
    input  logic                 d_ack,
    output logic                 wb_valid,
    output logic [1:0]           wb_dest,
    output logic [WORD_SIZE-1:0] wb_data
`ifdef DMA_ARB_EN
    ,
    input  logic                 BR,
    output logic                 BG
`endif
);

    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_BR_LIMIT = 4'd4;  // opcodes 0..3 are conditional branches

`ifdef DMA_ARB_EN
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, GRANT} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_t;
`endif

    state_t                 state_r, state_nxt_s;
    logic                   accept_s;
    logic                   is_branch_s;
    logic                   rd_req_r, wr_req_r;
    logic [WORD_SIZE-1:0]   addr_r, wdata_r, wb_data_r;
    logic [1:0]             dest_r, wb_dest_r;
    logic                   wb_valid_r;
`ifdef DMA_ARB_EN
    logic                   bg_r;
`endif

    // Upstream hold: any outstanding access, or a DMA request that wins over in_valid.
    always_comb begin
`ifdef DMA_ARB_EN
        stall = (state_r != IDLE) || BR;
`else
        stall = (state_r != IDLE);
`endif
    end

    assign accept_s    = in_valid && !stall;
    assign is_branch_s = (Opcode < OP_BR_LIMIT);

    // Next-state decode for the memory handshake and optional bus grant.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
`ifdef DMA_ARB_EN
                if (BR) begin
                    state_nxt_s = GRANT;
                end else
`endif
                if (accept_s && (Opcode == OP_LWD)) begin
                    state_nxt_s = READ_WAIT;
                end else if (accept_s && (Opcode == OP_SWD)) begin
                    state_nxt_s = WRITE_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ_WAIT: begin
                if (d_ack) state_nxt_s = IDLE;
                else       state_nxt_s = READ_WAIT;
            end
            WRITE_WAIT: begin
                if (d_ack) state_nxt_s = IDLE;
                else       state_nxt_s = WRITE_WAIT;
            end
`ifdef DMA_ARB_EN
            GRANT: begin
                if (!BR) state_nxt_s = IDLE;
                else     state_nxt_s = GRANT;
            end
`endif
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and request strobes, registered from the next state.
    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_r  <= IDLE;
            rd_req_r <= 1'b0;
            wr_req_r <= 1'b0;
`ifdef DMA_ARB_EN
            bg_r     <= 1'b0;
`endif
        end else begin
            state_r  <= state_nxt_s;
            rd_req_r <= (state_nxt_s == READ_WAIT);
            wr_req_r <= (state_nxt_s == WRITE_WAIT);
`ifdef DMA_ARB_EN
            bg_r     <= (state_nxt_s == GRANT);
`endif
        end
    end

    // Address/data latches and writeback pulse; bus fields clear when the access ends.
    always_ff @(posedge clk or negedge Reset_N) begin
        if (!Reset_N) begin
            addr_r     <= {WORD_SIZE{1'b0}};
            wdata_r    <= {WORD_SIZE{1'b0}};
            dest_r     <= 2'd0;
            wb_valid_r <= 1'b0;
            wb_data_r  <= {WORD_SIZE{1'b0}};
            wb_dest_r  <= 2'd0;
        end else begin
            wb_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (state_nxt_s == READ_WAIT) begin
                        addr_r <= ALUresult;
                        dest_r <= in_dest;
                    end else if (state_nxt_s == WRITE_WAIT) begin
                        addr_r  <= ALUresult;
                        wdata_r <= store_data;
                    end else if (accept_s && in_wen && !is_branch_s) begin
                        wb_valid_r <= 1'b1;
                        wb_data_r  <= ALUresult;
                        wb_dest_r  <= in_dest;
                    end
                end
                READ_WAIT: begin
                    if (d_ack) begin
                        wb_valid_r <= 1'b1;
                        wb_data_r  <= d_rdata;
                        wb_dest_r  <= dest_r;
                        addr_r     <= {WORD_SIZE{1'b0}};
                    end
                end
                WRITE_WAIT: begin
                    if (d_ack) begin
                        addr_r  <= {WORD_SIZE{1'b0}};
                        wdata_r <= {WORD_SIZE{1'b0}};
                    end
                end
                default: begin
                    addr_r  <= {WORD_SIZE{1'b0}};
                    wdata_r <= {WORD_SIZE{1'b0}};
                end
            endcase
        end
    end

    assign d_readM   = rd_req_r;
    assign d_writeM  = wr_req_r;
    assign d_address = addr_r;
    assign d_wdata   = wdata_r;
    assign wb_valid  = wb_valid_r;
    assign wb_data   = wb_data_r;
    assign wb_dest   = wb_dest_r;
`ifdef DMA_ARB_EN
    assign BG        = bg_r;
`endif

endmodule
